reg_status_file: RTL

- Architectural register file plus per-register rename status (busy bit, ROB tag).
- Upstream of the ROB on the read side: sends operand tags to the ROB and merges the ROB's ready/value answer into final operand info for dispatch.
- Downstream of the ROB on the commit side: consumes register commits and branch/JALR flush.

---
 rtl/reg_status_file_if.sv | 49 ++++
 rtl/reg_status_file.sv | 112 +++++++++++
 2 files changed

// File: rtl/reg_status_file_if.sv
// Dispatch-side bundle for reg_status_file: issue, operand read, ROB query, commit, flush.
// Latency: pure wiring, no storage.
// Backpressure: rdy is a global stall; there is no per-channel handshake.
interface reg_status_file_if #(
  parameter int REG_W = 5,
  parameter int TAG_W = 4
);
  logic             rdy;
  logic             iss_valid;
  logic [REG_W-1:0] iss_rd;
  logic [TAG_W-1:0] iss_tag;
  logic [REG_W-1:0] rs1_addr;
  logic [REG_W-1:0] rs2_addr;
  logic [TAG_W-1:0] rob_rs1_id;
  logic [TAG_W-1:0] rob_rs2_id;
  logic             rob_rs1_ready;
  logic [31:0]      rob_rs1_value;
  logic             rob_rs2_ready;
  logic [31:0]      rob_rs2_value;
  logic             op1_ready;
  logic [31:0]      op1_val;
  logic [TAG_W-1:0] op1_tag;
  logic             op2_ready;
  logic [31:0]      op2_val;
  logic [TAG_W-1:0] op2_tag;
  logic             cmt_valid;
  logic [REG_W-1:0] cmt_rd;
  logic [TAG_W-1:0] cmt_tag;
  logic [31:0]      cmt_val;
  logic             flush;

  // Register file side
  modport slave (
    input  rdy, iss_valid, iss_rd, iss_tag, rs1_addr, rs2_addr,
    input  rob_rs1_ready, rob_rs1_value, rob_rs2_ready, rob_rs2_value,
    input  cmt_valid, cmt_rd, cmt_tag, cmt_val, flush,
    output rob_rs1_id, rob_rs2_id,
    output op1_ready, op1_val, op1_tag, op2_ready, op2_val, op2_tag
  );

  // Dispatch / ROB side
  modport master (
    output rdy, iss_valid, iss_rd, iss_tag, rs1_addr, rs2_addr,
    output rob_rs1_ready, rob_rs1_value, rob_rs2_ready, rob_rs2_value,
    output cmt_valid, cmt_rd, cmt_tag, cmt_val, flush,
    input  rob_rs1_id, rob_rs2_id,
    input  op1_ready, op1_val, op1_tag, op2_ready, op2_val, op2_tag
  );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy bit + ROB tag).
// Latency: operand reads and commit bypass are combinational; renames/commits land next cycle.
// Backpressure: rdy=0 freezes all state; outputs stay valid.
module reg_status_file #(
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  reg_status_file_if.slave bus
);

  logic [31:0]      regs_q [NREG];
  logic [31:0]      regs_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];

  logic [REG_W-1:0] src_addr  [2];
  logic             src_rob_rdy [2];
  logic [31:0]      src_rob_val [2];
  logic             src_ready [2];
  logic [31:0]      src_val   [2];
  logic [TAG_W-1:0] src_tag   [2];
  logic [TAG_W-1:0] src_id    [2];

  assign src_addr[0]    = bus.rs1_addr;
  assign src_addr[1]    = bus.rs2_addr;
  assign src_rob_rdy[0] = bus.rob_rs1_ready;
  assign src_rob_rdy[1] = bus.rob_rs2_ready;
  assign src_rob_val[0] = bus.rob_rs1_value;
  assign src_rob_val[1] = bus.rob_rs2_value;

  // Operand resolution from pre-edge state: array, then commit bypass, then ROB answer
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_ready[s] = 1'b1;
      src_val[s]   = '0;
      src_tag[s]   = '0;
      src_id[s]    = '0;
      if (src_addr[s] == '0) begin
        // x0: always ready zero, never renamed
        src_ready[s] = 1'b1;
      end else if (!busy_q[src_addr[s]]) begin
        src_val[s] = regs_q[src_addr[s]];
      end else begin
        src_id[s] = tag_q[src_addr[s]];
        if (bus.cmt_valid && (bus.cmt_rd == src_addr[s]) &&
            (bus.cmt_tag == tag_q[src_addr[s]])) begin
          src_val[s] = bus.cmt_val;
        end else if (src_rob_rdy[s]) begin
          src_val[s] = src_rob_val[s];
        end else begin
          src_ready[s] = 1'b0;
          src_tag[s]   = tag_q[src_addr[s]];
        end
      end
    end
  end

  assign bus.rob_rs1_id = src_id[0];
  assign bus.rob_rs2_id = src_id[1];
  assign bus.op1_ready  = src_ready[0];
  assign bus.op1_val    = src_val[0];
  assign bus.op1_tag    = src_tag[0];
  assign bus.op2_ready  = src_ready[1];
  assign bus.op2_val    = src_val[1];
  assign bus.op2_tag    = src_tag[1];

  // Next state: commit first, then flush or issue override the status bits
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.rdy) begin
      if (bus.cmt_valid && (bus.cmt_rd != '0)) begin
        regs_d[bus.cmt_rd] = bus.cmt_val;
        // A younger rename of the same register keeps it busy
        if (tag_q[bus.cmt_rd] == bus.cmt_tag) begin
          busy_d[bus.cmt_rd] = 1'b0;
        end
      end
      if (bus.flush) begin
        busy_d = '0;
        for (int i = 0; i < NREG; i++) begin
          tag_d[i] = '0;
        end
      end else if (bus.iss_valid && (bus.iss_rd != '0)) begin
        busy_d[bus.iss_rd] = 1'b1;
        tag_d[bus.iss_rd]  = bus.iss_tag;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

endmodule
